// File: rtl/gshare_ras_predictor.sv
// ============================================================================
// Module      : gshare_ras_predictor
// Description : Gshare conditional-branch predictor with optional return
//               address stack (enabled by defining macro BP_RAS_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gshare_ras_predictor #(
    parameter int HIST_W    = 4,
    parameter int IDX_W     = 6,
    parameter int CTR_W     = 2,
    parameter int RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        ready_in,
    input  logic [31:0] trap_raddr_csr,
    input  logic [31:0] PC_IF,
    input  logic [31:0] IM_IF,
    input  logic        jump_ena_IF,
    input  logic        jump_alw_IF,
    input  logic        jump_ind_IF,
    input  logic        trap_ret_IF,
    input  logic        call_IF,
    input  logic        ret_IF,
    output logic        jump_pred_IF,
    output logic [31:0] jump_addr_IF,
    input  logic [31:0] PC_EX,
    input  logic        jump_ena_EX,
    input  logic        jump_alw_EX,
    input  logic        jump_taken_EX,
    input  logic        flush_EX
);

    localparam int             c_PHT_N   = 1 << IDX_W;
    localparam logic [CTR_W-1:0] c_CTR_MAX = {CTR_W{1'b1}};

    logic [HIST_W-1:0] r_ghr;
    logic [HIST_W-1:0] w_ghr_next;
    logic [CTR_W-1:0]  r_pht [c_PHT_N];
    logic [IDX_W-1:0]  w_ghr_ext;
    logic [IDX_W-1:0]  w_ridx;
    logic [IDX_W-1:0]  w_widx;
    logic [CTR_W-1:0]  w_wctr;
    logic              w_upd;
    logic              w_pht_msb;
    logic              w_ras_valid;
    logic [31:0]       w_ras_top;
    logic              w_unused_pc;

    assign w_ghr_ext   = IDX_W'(r_ghr);
    assign w_ridx      = PC_IF[IDX_W+1:2] ^ w_ghr_ext;
    assign w_widx      = PC_EX[IDX_W+1:2] ^ w_ghr_ext;
    assign w_wctr      = r_pht[w_widx];
    assign w_upd       = ready_in && jump_ena_EX && !jump_alw_EX;
    // Asynchronous read of the table returns the pre-update value on collision
    assign w_pht_msb   = r_pht[w_ridx][CTR_W-1];
    assign w_unused_pc = ^{PC_EX[31:IDX_W+2], PC_EX[1:0]};

    generate
        if (HIST_W == 1) begin : g_ghr_single
            assign w_ghr_next = jump_taken_EX;
        end else begin : g_ghr_shift
            assign w_ghr_next = {r_ghr[HIST_W-2:0], jump_taken_EX};
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ghr <= '0;
            for (int i = 0; i < c_PHT_N; i++) begin
                r_pht[i] <= c_CTR_MAX;
            end
        end else if (w_upd) begin
            r_ghr <= w_ghr_next;
            if (jump_taken_EX && (w_wctr != c_CTR_MAX)) begin
                r_pht[w_widx] <= w_wctr + CTR_W'(1);
            end else if (!jump_taken_EX && (w_wctr != '0)) begin
                r_pht[w_widx] <= w_wctr - CTR_W'(1);
            end
        end
    end

`ifdef BP_RAS_EN
    localparam int                 c_PTR_W    = $clog2(RAS_DEPTH);
    localparam logic [c_PTR_W:0]   c_RAS_FULL = (c_PTR_W+1)'(RAS_DEPTH);

    logic [31:0]        r_ras [RAS_DEPTH];
    logic [c_PTR_W-1:0] r_top;
    logic [c_PTR_W:0]   r_cnt;
    logic               w_push;
    logic               w_pop;
    logic [31:0]        w_link;

    assign w_ras_valid = (r_cnt != '0);
    assign w_ras_top   = r_ras[r_top];
    assign w_push      = valid_in && ready_in && call_IF;
    assign w_pop       = valid_in && ready_in && ret_IF && w_ras_valid;
    assign w_link      = PC_IF + 32'd4;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_top <= '0;
            r_cnt <= '0;
        end else if (flush_EX) begin
            r_cnt <= '0;
        end else if (w_push && !w_pop) begin
            r_top <= r_top + c_PTR_W'(1);
            if (r_cnt != c_RAS_FULL) begin
                r_cnt <= r_cnt + (c_PTR_W+1)'(1);
            end
        end else if (w_pop && !w_push) begin
            r_top <= r_top - c_PTR_W'(1);
            r_cnt <= r_cnt - (c_PTR_W+1)'(1);
        end
    end

    // Entry contents need no reset; a full stack overwrites its oldest slot
    always_ff @(posedge clk) begin
        if (!flush_EX) begin
            if (w_push && w_pop) begin
                r_ras[r_top] <= w_link;
            end else if (w_push) begin
                r_ras[r_top + c_PTR_W'(1)] <= w_link;
            end
        end
    end
`else
    logic w_unused_ras;

    assign w_ras_valid  = 1'b0;
    assign w_ras_top    = '0;
    assign w_unused_ras = ^{call_IF, flush_EX};
`endif

    assign jump_pred_IF = !reset && valid_in && jump_ena_IF &&
                          (trap_ret_IF || (ret_IF && w_ras_valid) ||
                           (!jump_ind_IF && (jump_alw_IF || w_pht_msb)));

    always_comb begin
        jump_addr_IF = PC_IF + IM_IF;
        if (trap_ret_IF) begin
            jump_addr_IF = trap_raddr_csr;
        end else if (ret_IF && w_ras_valid) begin
            jump_addr_IF = w_ras_top;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gshare_ras_predictor.sv
// ============================================================================
// Module      : tb_gshare_ras_predictor
// Description : Directed self-checking bench for gshare_ras_predictor; RAS
//               expectations follow macro BP_RAS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gshare_ras_predictor;

`ifdef BP_RAS_EN
    localparam bit c_RAS = 1'b1;
`else
    localparam bit c_RAS = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic        ready_in;
    logic [31:0] trap_raddr_csr;
    logic [31:0] PC_IF;
    logic [31:0] IM_IF;
    logic        jump_ena_IF;
    logic        jump_alw_IF;
    logic        jump_ind_IF;
    logic        trap_ret_IF;
    logic        call_IF;
    logic        ret_IF;
    logic        jump_pred_IF;
    logic [31:0] jump_addr_IF;
    logic [31:0] PC_EX;
    logic        jump_ena_EX;
    logic        jump_alw_EX;
    logic        jump_taken_EX;
    logic        flush_EX;

    int n_vec;
    int n_err;

    gshare_ras_predictor #(
        .HIST_W    (4),
        .IDX_W     (6),
        .CTR_W     (2),
        .RAS_DEPTH (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .valid_in       (valid_in),
        .ready_in       (ready_in),
        .trap_raddr_csr (trap_raddr_csr),
        .PC_IF          (PC_IF),
        .IM_IF          (IM_IF),
        .jump_ena_IF    (jump_ena_IF),
        .jump_alw_IF    (jump_alw_IF),
        .jump_ind_IF    (jump_ind_IF),
        .trap_ret_IF    (trap_ret_IF),
        .call_IF        (call_IF),
        .ret_IF         (ret_IF),
        .jump_pred_IF   (jump_pred_IF),
        .jump_addr_IF   (jump_addr_IF),
        .PC_EX          (PC_EX),
        .jump_ena_EX    (jump_ena_EX),
        .jump_alw_EX    (jump_alw_EX),
        .jump_taken_EX  (jump_taken_EX),
        .flush_EX       (flush_EX)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        valid_in      = 1'b0;
        ready_in      = 1'b1;
        PC_IF         = '0;
        IM_IF         = '0;
        jump_ena_IF   = 1'b0;
        jump_alw_IF   = 1'b0;
        jump_ind_IF   = 1'b0;
        trap_ret_IF   = 1'b0;
        call_IF       = 1'b0;
        ret_IF        = 1'b0;
        PC_EX         = '0;
        jump_ena_EX   = 1'b0;
        jump_alw_EX   = 1'b0;
        jump_taken_EX = 1'b0;
        flush_EX      = 1'b0;
    endtask

    task automatic drive_if(input logic [31:0] pc, input logic [31:0] im, input logic ena,
                            input logic alw, input logic ind, input logic call,
                            input logic ret, input logic trap);
        valid_in    = 1'b1;
        PC_IF       = pc;
        IM_IF       = im;
        jump_ena_IF = ena;
        jump_alw_IF = alw;
        jump_ind_IF = ind;
        call_IF     = call;
        ret_IF      = ret;
        trap_ret_IF = trap;
    endtask

    task automatic drive_ex(input logic [31:0] pc, input logic alw, input logic taken);
        PC_EX         = pc;
        jump_ena_EX   = 1'b1;
        jump_alw_EX   = alw;
        jump_taken_EX = taken;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic call_at(input logic [31:0] pc);
        idle();
        drive_if(pc, 32'h100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
    endtask

    // Return fetched at 0x200 with offset 8; unpredicted target is 0x208
    task automatic ret_check(input string tag, input logic hit, input logic [31:0] tgt);
        idle();
        drive_if(32'h200, 32'h8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        check({tag, "_pred"}, 32'(jump_pred_IF), 32'(c_RAS && hit));
        check({tag, "_addr"}, jump_addr_IF, (c_RAS && hit) ? tgt : 32'h208);
        tick();
    endtask

    task automatic cond_check(input string tag, input logic [31:0] pc, input logic exp);
        idle();
        drive_if(pc, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check(tag, 32'(jump_pred_IF), 32'(exp));
    endtask

    initial begin
        n_vec          = 0;
        n_err          = 0;
        reset          = 1'b1;
        trap_raddr_csr = 32'h8000_0000;
        idle();
        drive_if(32'h100, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        check("reset_pred", 32'(jump_pred_IF), 32'h0);
        reset = 1'b0;
        #1;
        check("br_pred", 32'(jump_pred_IF), 32'h1);
        check("br_addr", jump_addr_IF, 32'h140);

        // Counter at index 0 walks 3 -> 2 -> 1 with GHR staying 0
        idle(); drive_ex(32'h100, 1'b0, 1'b0); tick();
        cond_check("ctr2_pred", 32'h100, 1'b1);
        drive_ex(32'h100, 1'b0, 1'b0);
        #1;
        check("collide_pre", 32'(jump_pred_IF), 32'h1);
        tick();
        cond_check("ctr1_pred", 32'h100, 1'b0);

        idle(); drive_ex(32'h100, 1'b1, 1'b0); tick();
        idle(); drive_ex(32'h100, 1'b0, 1'b1); tick();
        cond_check("ghr_xor_pred", 32'h104, 1'b1);
        idle(); drive_ex(32'h104, 1'b0, 1'b0); tick();
        cond_check("hist_idx0_pred", 32'h108, 1'b0);
        cond_check("hist_idx2_pred", 32'h100, 1'b1);
        idle(); drive_ex(32'h108, 1'b0, 1'b0); tick();
        idle(); drive_ex(32'h110, 1'b0, 1'b0); tick();
        cond_check("sat_low_pred", 32'h120, 1'b0);

        idle(); ready_in = 1'b0; drive_ex(32'h120, 1'b0, 1'b1); tick();
        ready_in = 1'b0; drive_ex(32'h120, 1'b0, 1'b1); tick();
        cond_check("stall_pred", 32'h120, 1'b0);

        idle(); drive_if(32'h120, 32'h10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        check("jal_pred", 32'(jump_pred_IF), 32'h1);
        check("jal_addr", jump_addr_IF, 32'h130);
        jump_ind_IF = 1'b1; #1;
        check("jalr_pred", 32'(jump_pred_IF), 32'h0);
        jump_ind_IF = 1'b0; valid_in = 1'b0; #1;
        check("novalid_pred", 32'(jump_pred_IF), 32'h0);

        call_at(32'h10); call_at(32'h20); call_at(32'h30);
        ret_check("r3a", 1'b1, 32'h34);
        ret_check("r3b", 1'b1, 32'h24);
        ret_check("r3c", 1'b1, 32'h14);
        ret_check("r3d", 1'b0, 32'h0);

        for (int i = 0; i < 5; i++) call_at(32'h40 + 32'(i) * 32'h10);
        for (int i = 0; i < 5; i++) ret_check("ovf", i < 4, 32'h84 - 32'(i) * 32'h10);

        call_at(32'h90); call_at(32'hA0);
        idle(); drive_if(32'hB0, 32'h8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0); #1;
        check("pushpop_pred", 32'(jump_pred_IF), 32'(c_RAS));
        check("pushpop_addr", jump_addr_IF, c_RAS ? 32'hA4 : 32'hB8);
        tick();
        ret_check("pp_a", 1'b1, 32'hB4);
        ret_check("pp_b", 1'b1, 32'h94);
        ret_check("pp_c", 1'b0, 32'h0);

        call_at(32'hC0);
        idle(); drive_if(32'hD0, 32'h100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        flush_EX = 1'b1; drive_ex(32'h200, 1'b0, 1'b0); tick();
        ret_check("flush", 1'b0, 32'h0);
        cond_check("flush_upd_pred", 32'h120, 1'b1);

        call_at(32'hE0);
        cond_check("pre_rst_pred", 32'h100, 1'b0);
        reset = 1'b1; #1;
        check("midrst_pred", 32'(jump_pred_IF), 32'h0);
        reset = 1'b0; #1;
        check("rst_pht_pred", 32'(jump_pred_IF), 32'h1);
        ret_check("rst_ras", 1'b0, 32'h0);

        call_at(32'hF0);
        idle(); drive_if(32'h300, 32'h8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1); #1;
        check("trap_pred", 32'(jump_pred_IF), 32'h1);
        check("trap_addr", jump_addr_IF, 32'h8000_0000);
        tick();
        ret_check("post_trap", 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gshare_ras_predictor.md
GSHARE_RAS_PREDICTOR -- requirements
Module: gshare_ras_predictor

Interface
REQ-001 SHALL have parameter HIST_W, default 4: global history register (GHR) width in bits; legal range 1..IDX_W.
REQ-002 SHALL have parameter IDX_W, default 6: pattern history table (PHT) index width; PHT has 2**IDX_W entries.
REQ-003 SHALL have parameter CTR_W, default 2: PHT saturating counter width; legal range 1..4.
REQ-004 SHALL have parameter RAS_DEPTH, default 4: return address stack (RAS) entries; power of two, at least 2.
REQ-005 SHALL have ports: clk  in  1  clock; reset  in  1  asynchronous active-high reset.
REQ-006 SHALL have ports: valid_in  in  1  IF instruction valid; ready_in  in  1  pipeline advancing this cycle.
REQ-007 SHALL have ports: trap_raddr_csr  in  32  trap return address; PC_IF  in  32  fetch PC; IM_IF  in  32  decoded jump offset.
REQ-008 SHALL have ports: jump_ena_IF, jump_alw_IF, jump_ind_IF, trap_ret_IF  in  1 each  IF control-transfer decode (any jump, unconditional, indirect, MRET).
REQ-009 SHALL have ports: call_IF  in  1  call (JAL/JALR with link register ra); ret_IF  in  1  return (JALR via ra, no link).
REQ-010 SHALL have ports: jump_pred_IF  out  1  predicted taken; jump_addr_IF  out  32  predicted target.
REQ-011 SHALL have ports: PC_EX  in  32; jump_ena_EX, jump_alw_EX, jump_taken_EX  in  1 each  resolved outcome; flush_EX  in  1  mispredict flush.

Function
REQ-012 SHALL form read index as PC_IF[IDX_W+1:2] XOR zero-extended GHR, and write index as PC_EX[IDX_W+1:2] XOR zero-extended GHR.
REQ-013 SHALL update on ready_in && jump_ena_EX && !jump_alw_EX only: GHR <= {GHR[HIST_W-2:0], jump_taken_EX}; PHT[write index] increments if taken, decrements if not; saturates at all-ones and 0.
REQ-014 SHALL predict a conditional branch taken when the MSB of PHT[read index] is set; prediction is combinational, zero-cycle latency.
REQ-015 SHALL return the pre-update counter value when the read and write indices collide in the same cycle; the update is visible from the next cycle.
REQ-016 SHALL drive jump_pred_IF = valid_in && jump_ena_IF && (trap_ret_IF || (ret_IF && RAS non-empty) || (!jump_ind_IF && (jump_alw_IF || PHT MSB))).
REQ-017 SHALL drive jump_addr_IF = trap_raddr_csr if trap_ret_IF; else RAS top if ret_IF && RAS non-empty; else PC_IF + IM_IF (modulo 2**32).
REQ-018 SHALL push PC_IF + 4 on valid_in && ready_in && call_IF; SHALL pop on valid_in && ready_in && ret_IF && RAS non-empty.
REQ-019 SHALL implement the RAS as a circular buffer with top pointer and count (0..RAS_DEPTH); the top pointer wraps modulo RAS_DEPTH.
REQ-020 SHALL overwrite the oldest entry on push when full; count stays RAS_DEPTH.
REQ-021 SHALL, on pop when empty, make no state change and no RAS prediction.
REQ-022 SHALL, on simultaneous push and pop, replace the top entry; pointer and count unchanged.
REQ-023 SHALL, on flush_EX, set count to 0; flush_EX overrides a same-cycle push or pop; GHR/PHT update in that cycle still occurs.

Reset
REQ-024 SHALL, on reset assert, immediately clear GHR to 0, RAS pointer and count to 0, and set every PHT counter to all-ones (strongly taken).
REQ-025 SHALL clear jump_pred_IF while reset is asserted; RAS entry contents are don't-care after reset.

Configuration
REQ-026 SHALL compile the RAS in when macro BP_RAS_EN is defined, implementing REQ-016..REQ-023 in full.
REQ-027 SHALL, without BP_RAS_EN, contain no RAS storage and ignore call_IF, ret_IF and flush_EX; returns are then predicted as indirect (not taken).

Verification
REQ-028 SHALL cover: reset, branch at PC_IF=0x100 -> jump_pred_IF=1, jump_addr_IF=0x100+IM_IF.
REQ-029 SHALL cover: two not-taken resolutions at the same index (GHR held) -> counter 3->1, next prediction at that index = 0.
REQ-030 SHALL cover: calls at 0x10, 0x20, 0x30, then three returns -> targets 0x34, 0x24, 0x14 in order, fourth return not predicted.
REQ-031 SHALL cover: RAS_DEPTH+1 calls, then RAS_DEPTH+1 returns -> the oldest address is lost, and the last return is not predicted.
REQ-032 SHALL cover: push and pop in one cycle, flush_EX with push, and reset mid-sequence -> behaviour per REQ-022, REQ-023, REQ-024.
REQ-033 SHALL cover: trap_ret_IF with ret_IF both set -> jump_addr_IF = trap_raddr_csr; repeat without BP_RAS_EN -> a plain return gives jump_pred_IF=0.
